maxpool2x2_stream: RTL and testbench



---
 rtl/cnn_pkg.sv | 11 +
 rtl/pool_linebuf.sv | 19 +
 rtl/maxpool2x2_stream.sv | 84 ++++++++
 tb/tb_maxpool2x2_stream.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// cnn_pkg: activation type, signed max helper and default layer geometry
package cnn_pkg;
   localparam int ACT_W = 8;
   localparam int DEF_OUT_CH = 16;
   localparam int DEF_IMG_W = 32;
   localparam int DEF_IMG_H = 32;
   typedef logic signed [ACT_W-1:0] act_t;
   function automatic act_t act_max(input act_t a, input act_t b);
      return (a > b) ? a : b;
   endfunction
endpackage

// File: rtl/pool_linebuf.sv
// pool_linebuf: one row of horizontal pair maxima, single write port, combinational read
module pool_linebuf #(
   parameter int DEPTH = 16,
   parameter int OUT_CH = 16,
   parameter int DATA_W = 8,
   parameter int AW = 4
) (
   input  logic                          clk,
   input  logic                          we,
   input  logic [AW-1:0]                 waddr,
   input  logic [OUT_CH-1:0][DATA_W-1:0] wdata,
   input  logic [AW-1:0]                 raddr,
   output logic [OUT_CH-1:0][DATA_W-1:0] rdata
);
   logic [OUT_CH-1:0][DATA_W-1:0] mem [DEPTH];
   always_ff @(posedge clk)
      if (we) mem[waddr] <= wdata;
   assign rdata = mem[raddr];
endmodule

// File: rtl/maxpool2x2_stream.sv
// maxpool2x2_stream: streaming 2x2 stride-2 signed max-pool over raster-order pixels
module maxpool2x2_stream
   import cnn_pkg::*;
#(
   parameter int DATA_W = ACT_W,
   parameter int OUT_CH = DEF_OUT_CH,
   parameter int IMG_W = DEF_IMG_W,
   parameter int IMG_H = DEF_IMG_H
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          clear,
   input  logic [OUT_CH-1:0][DATA_W-1:0] in_data,
   input  logic                          in_valid,
   output logic [OUT_CH-1:0][DATA_W-1:0] out_data,
   output logic                          out_valid,
   output logic                          out_last,
   output logic                          frame_err
);
   localparam int CW = $clog2(IMG_W);
   localparam int RW = (IMG_H > 2) ? $clog2(IMG_H) : 1;
   localparam int AW = (IMG_W > 2) ? $clog2(IMG_W / 2) : 1;
   localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);

   if ((IMG_W % 2) != 0 || (IMG_H % 2) != 0 || IMG_W < 2 || IMG_H < 2 || DATA_W != ACT_W) begin : g_param_err
      $error("maxpool2x2_stream: IMG_W/IMG_H must be even and >=2, DATA_W must match act_t");
   end

   logic [CW-1:0] col;
   logic [RW-1:0] row;
   logic [OUT_CH-1:0][DATA_W-1:0] h_reg, wmax, omax, lb_rd;
   logic acc, last_col, last_row, lb_we, win_done;
   logic [AW-1:0] c2;

   assign acc = in_valid && !clear;
   assign last_col = col == COL_MAX;
   assign last_row = row == ROW_MAX;
   assign c2 = AW'(col >> 1);
   assign lb_we = acc && !row[0] && col[0];
   assign win_done = acc && row[0] && col[0];

   always_comb begin
      for (int k = 0; k < OUT_CH; k++) begin
         wmax[k] = act_max(h_reg[k], in_data[k]);
         omax[k] = act_max(lb_rd[k], wmax[k]);
      end
   end

   pool_linebuf #(.DEPTH(IMG_W / 2), .OUT_CH(OUT_CH), .DATA_W(DATA_W), .AW(AW)) u_linebuf (
      .clk(clk),
      .we(lb_we),
      .waddr(c2),
      .wdata(wmax),
      .raddr(c2),
      .rdata(lb_rd)
   );

   // h_reg holds the left pixel of the current pair; its value is don't-care after reset
   always_ff @(posedge clk)
      if (acc && !col[0]) h_reg <= in_data;

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         col <= '0;
         row <= '0;
         out_data <= '0;
         out_valid <= 1'b0;
         out_last <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         out_valid <= win_done;
         out_last <= acc && last_col && last_row;
         frame_err <= frame_err | (in_valid & clear);
         if (win_done) out_data <= omax;
         if (clear) begin
            col <= '0;
            row <= '0;
         end else if (in_valid) begin
            col <= last_col ? '0 : col + 1'b1;
            if (last_col) row <= last_row ? '0 : row + 1'b1;
         end
      end
endmodule

// File: tb/tb_maxpool2x2_stream.sv
// tb_maxpool2x2_stream: random and directed stimulus against a frame-array reference model
module tb_maxpool2x2_stream;
   localparam int W = 4, H = 4, CH = 2, DW = 8;
   localparam int E0[4] = '{5, 7, 13, 15};
   localparam int E1[4] = '{0, -2, -8, -10};
   localparam int EP[4] = '{6, 8, 14, 16};
   localparam int E2[8] = '{5, 7, 13, 15, 100, 98, 92, 90};

   logic clk = 0, rst = 1, clear = 0, in_valid = 0;
   logic [CH-1:0][DW-1:0] in_data = '0;
   logic [CH-1:0][DW-1:0] out_data;
   logic out_valid, out_last, frame_err;

   maxpool2x2_stream #(.DATA_W(DW), .OUT_CH(CH), .IMG_W(W), .IMG_H(H)) dut (
      .clk(clk), .rst(rst), .clear(clear), .in_data(in_data), .in_valid(in_valid),
      .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   int n_tests = 0, n_fail = 0;
   int fr0[H][W], fr1[H][W];
   int idx = 0, pcnt = 0;
   int exp_v = 0, exp_l = 0, exp_err = 0, exp_d0 = 0, exp_d1 = 0;
   typedef struct {int c0; int c1; int l; int p;} ent_t;
   ent_t olog[$];

   task automatic chk(input string nm, input int act, input int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic int mx(input int a, input int b);
      return a > b ? a : b;
   endfunction

   function automatic int rnd();
      return int'($urandom_range(255, 0)) - 128;
   endfunction

   // Reference: place each accepted pixel at its raster position, pool when a window completes
   task automatic model(input bit v, input bit c, input int d0, input int d1);
      if (c) begin
         if (v) exp_err = 1;
         idx = 0;
         exp_v = 0;
         exp_l = 0;
      end else if (v) begin
         int r, cc;
         r = idx / W;
         cc = idx % W;
         fr0[r][cc] = d0;
         fr1[r][cc] = d1;
         pcnt++;
         if (r % 2 == 1 && cc % 2 == 1) begin
            exp_v = 1;
            exp_d0 = mx(mx(fr0[r-1][cc-1], fr0[r-1][cc]), mx(fr0[r][cc-1], fr0[r][cc]));
            exp_d1 = mx(mx(fr1[r-1][cc-1], fr1[r-1][cc]), mx(fr1[r][cc-1], fr1[r][cc]));
            exp_l = (idx == W * H - 1) ? 1 : 0;
         end else begin
            exp_v = 0;
            exp_l = 0;
         end
         idx = (idx + 1) % (W * H);
      end else begin
         exp_v = 0;
         exp_l = 0;
      end
   endtask

   task automatic cyc(input bit v, input bit c, input int d0, input int d1);
      in_valid = v;
      clear = c;
      in_data[0] = DW'(d0);
      in_data[1] = DW'(d1);
      @(posedge clk);
      model(v, c, d0, d1);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) cyc(0, 0, rnd(), rnd());
   endtask

   task automatic frame(input int kind, input int gap);
      for (int i = 0; i < W * H; i++) begin
         int r, c, d0, d1;
         r = i / W;
         c = i % W;
         d0 = rnd();
         d1 = rnd();
         if (kind == 0) begin
            d0 = r * W + c;
            d1 = -(r * W + c);
         end else if (kind == 1) begin
            d0 = 100 - i;
            d1 = i;
         end else if (kind == 3) begin
            if (i == 5) d0 = 127;
            else if (i < 8 && i != 5) d0 = -128;
         end
         repeat ($urandom_range(gap, 0)) cyc(0, 0, rnd(), rnd());
         cyc(1, 0, d0, d1);
      end
   endtask

   task automatic check_basic(input string nm);
      chk($sformatf("%s_count", nm), olog.size(), 4);
      for (int i = 0; i < 4 && i < olog.size(); i++) begin
         chk($sformatf("%s_ch0_%0d", nm, i), olog[i].c0, E0[i]);
         chk($sformatf("%s_ch1_%0d", nm, i), olog[i].c1, E1[i]);
         chk($sformatf("%s_last_%0d", nm, i), olog[i].l, (i == 3) ? 1 : 0);
         chk($sformatf("%s_pix_%0d", nm, i), olog[i].p, EP[i]);
      end
   endtask

   always @(negedge clk) begin
      chk("out_valid", int'(out_valid), exp_v);
      chk("out_last", int'(out_last), exp_l);
      chk("frame_err", int'(frame_err), exp_err);
      chk("out_ch0", $signed(out_data[0]), exp_d0);
      chk("out_ch1", $signed(out_data[1]), exp_d1);
      if (out_valid) olog.push_back('{$signed(out_data[0]), $signed(out_data[1]), int'(out_last), pcnt});
   end

   initial begin
      repeat (2) @(posedge clk);
      #1 rst = 0;
      chk("reset_out_data", int'(out_data), 0);

      olog.delete(); pcnt = 0;
      frame(0, 0); idle(2);
      check_basic("basic");

      olog.delete(); pcnt = 0;
      frame(0, 3); idle(2);
      check_basic("gaps");

      olog.delete();
      frame(3, 1); idle(2);
      chk("extreme_count", olog.size(), 4);
      if (olog.size() >= 2) begin
         chk("extreme_mixed", olog[0].c0, 127);
         chk("extreme_all_min", olog[1].c0, -128);
      end

      olog.delete();
      frame(0, 0); frame(1, 0); idle(2);
      chk("two_frames_count", olog.size(), 8);
      for (int i = 0; i < 8 && i < olog.size(); i++) begin
         chk($sformatf("two_frames_ch0_%0d", i), olog[i].c0, E2[i]);
         chk($sformatf("two_frames_last_%0d", i), olog[i].l, (i == 3 || i == 7) ? 1 : 0);
      end

      for (int i = 0; i < 6; i++) cyc(1, 0, i, -i);
      cyc(0, 1, 0, 0);
      olog.delete(); pcnt = 0;
      frame(0, 0); idle(2);
      check_basic("clear_idle");
      chk("clear_idle_err", int'(frame_err), 0);

      for (int i = 0; i < 3; i++) cyc(1, 0, i, -i);
      cyc(1, 1, 55, 55);
      idle(1);
      chk("frame_err_set", int'(frame_err), 1);
      olog.delete(); pcnt = 0;
      frame(0, 0); idle(2);
      check_basic("after_drop");

      repeat (3) begin
         int n;
         n = $urandom_range(15, 1);
         for (int i = 0; i < n; i++) cyc(1, 0, rnd(), rnd());
         cyc(0, 1, 0, 0);
         frame(2, 2);
      end
      idle(2);

      for (int i = 0; i < 6; i++) cyc(1, 0, i, -i);
      chk("pre_rst_valid", int'(out_valid), 1);
      #1;
      rst = 1;
      idx = 0; exp_v = 0; exp_l = 0; exp_err = 0; exp_d0 = 0; exp_d1 = 0;
      #1;
      chk("async_rst_data", int'(out_data), 0);
      chk("async_rst_valid", int'(out_valid), 0);
      chk("async_rst_err", int'(frame_err), 0);
      @(posedge clk);
      #1 rst = 0;
      olog.delete(); pcnt = 0;
      frame(0, 0); idle(2);
      check_basic("after_rst");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
